// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states,
// and the default datapath width.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_BEQ  = 4'b1001,
    OP_BNE  = 4'b1010,
    OP_BLT  = 4'b1011,
    OP_BGE  = 4'b1100,
    OP_SLTU = 4'b1101,
    OP_BLTU = 4'b1110,
    OP_BGEU = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_exec_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU functions and branch compares. Shift codes pass src_a
// through, which is the correct answer for a zero shift amount.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  alu_op_t        i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [W-1:0]   o_result,
  output logic           o_branch
);

  logic w_lt_s;
  logic w_lt_u;
  logic w_eq;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;
  assign w_eq   = i_a == i_b;

  always_comb begin
    o_result = '0;
    o_branch = 1'b0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(W-1){1'b0}}, w_lt_s};
      OP_SLTU: o_result = {{(W-1){1'b0}}, w_lt_u};
      OP_SLL, OP_SRL, OP_SRA: o_result = i_a;
      OP_BEQ:  o_branch = w_eq;
      OP_BNE:  o_branch = !w_eq;
      OP_BLT:  o_branch = w_lt_s;
      OP_BGE:  o_branch = !w_lt_s;
      OP_BLTU: o_branch = w_lt_u;
      OP_BGEU: o_branch = !w_lt_u;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake. Single-cycle ops retire the
// cycle after accept; shifts iterate one bit per cycle before retiring.
module alu_exec_unit #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken
);

  import alu_pkg::*;

  localparam int              SHW     = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0]  CNT_ONE = 1;

  alu_exec_state_t       r_state;
  alu_exec_state_t       w_next;
  alu_op_t               r_kind;
  alu_op_t               w_op;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] w_core_res;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [SHW-1:0]        r_cnt;
  logic [SHW-1:0]        w_amt;
  logic                  r_branch;
  logic                  w_core_br;
  logic                  w_accept;
  logic                  w_go_shift;

  assign w_op       = alu_op_t'(operation);
  assign w_amt      = src_b[SHW-1:0];
  assign w_go_shift = is_shift(w_op) && (w_amt != '0);

  // Ready depends only on state, out_ready and flush, never on in_valid.
  assign in_ready  = !flush && ((r_state == ST_IDLE) ||
                                ((r_state == ST_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign result       = r_result;
  assign branch_taken = r_branch;

  alu_core #(.W(DATA_WIDTH)) u_core (
    .i_op     (w_op),
    .i_a      (src_a),
    .i_b      (src_b),
    .o_result (w_core_res),
    .o_branch (w_core_br)
  );

  always_comb begin
    w_shifted = r_work;
    case (r_kind)
      OP_SLL:  w_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
      OP_SRA:  w_shifted = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
      default: w_shifted = r_work;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else if (w_accept) begin
      w_next = w_go_shift ? ST_SHIFT : ST_DONE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_IDLE;
        ST_SHIFT: if (r_cnt == CNT_ONE) w_next = ST_DONE;
        ST_DONE:  if (out_ready) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_kind   <= OP_AND;
      r_result <= '0;
      r_branch <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_go_shift) begin
        r_work <= src_a;
        r_cnt  <= w_amt;
        r_kind <= w_op;
      end else begin
        r_result <= w_core_res;
        r_branch <= w_core_br;
      end
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - CNT_ONE;
      // Last step lands directly in the output register.
      if (r_cnt == CNT_ONE) begin
        r_result <= w_shifted;
        r_branch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench: the driver queues expected results from a reference model,
// a negedge monitor pops and compares whenever an output retires.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  operation = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic rand_rdy = 1'b0;

  logic        hold_prev = 1'b0;
  logic        flush_prev = 1'b0;
  logic [31:0] hold_res;
  logic        hold_br;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operation    (operation),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    int   sh;
    e.res = '0;
    e.br  = 1'b0;
    sh = int'(b % 32);
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd3:  e.res = a - b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  e.res = a << sh;
      4'd7:  e.res = a >> sh;
      4'd8:  e.res = 32'($signed(a) >>> sh);
      4'd9:  e.br  = (a == b);
      4'd10: e.br  = (a != b);
      4'd11: e.br  = ($signed(a) < $signed(b));
      4'd12: e.br  = ($signed(a) >= $signed(b));
      4'd13: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd14: e.br  = (a < b);
      default: e.br = (a >= b);
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready && !reset) begin
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout op %0d got no in_ready want in_ready", op);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Monitor: retirement compare plus output stability under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (hold_prev && !flush_prev) begin
        checks++;
        if (!(out_valid && result === hold_res && branch_taken === hold_br)) begin
          errors++;
          $display("FAIL hold_stable got v=%b %h/%b want v=1 %h/%b",
                   out_valid, result, branch_taken, hold_res, hold_br);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h/%b want no output", result, branch_taken);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || branch_taken !== e.br) begin
            errors++;
            $display("FAIL sb_compare got %h/%b want %h/%b", result, branch_taken, e.res, e.br);
          end
        end
      end
      hold_prev  = out_valid && !out_ready;
      hold_res   = result;
      hold_br    = branch_taken;
      flush_prev = flush;
    end else begin
      hold_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int seen;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_branch", {31'b0, branch_taken}, 32'd0);
    #21 reset = 1'b0;
    @(posedge clk); #1;

    send(4'd2, 32'h0000_0005, 32'hFFFF_FFFF);
    @(negedge clk);
    check("add_latency_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;

    send(4'd8, 32'h8000_0000, 32'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("sra_in_ready_low", {30'b0, in_ready, out_valid}, 32'd0);
    end
    @(negedge clk);
    check("sra_valid_at_5", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;

    send(4'd7, 32'h8000_0000, 32'd4);
    repeat (6) @(posedge clk);
    #1;

    send(4'd11, 32'hFFFF_FFFF, 32'd1);
    send(4'd14, 32'hFFFF_FFFF, 32'd1);
    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(4'd3, 32'd3, 32'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_result", result, 32'hFFFF_FFFE);
      check("hold_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    send(4'd2, 32'd1, 32'd2);
    @(negedge clk);
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;

    send(4'd6, 32'd1, 32'd31);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_idle_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_output", seen, 0);
    @(posedge clk); #1;

    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = {27'b0, b[4:0]};
      send(op, a, b);
    end
    seen = 0;
    while (sb.size() != 0 && seen < 500) begin
      @(posedge clk);
      seen++;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    check("random_drained", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    send(4'd1, 32'h0000_1234, 32'd0);
    @(posedge clk); #1;
    send(4'd7, 32'hFFFF_FFFF, 32'd20);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("amid_out_valid", {31'b0, out_valid}, 32'd0);
    check("amid_result", result, 32'd0);
    check("amid_branch", {31'b0, branch_taken}, 32'd0);
    check("amid_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("areset_no_output", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
